fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 16x8 fifo between NUM_REQ producers.
//  Uses round-robin arbitration with bounded bursts: the owner holds the port for up to MAX_BURST accepted words, then ownership rotates.
//  Sits directly in front of fifo.wr_en/data_in and consumes fifo.full.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  DATA_W     8  word width; matches fifo data_in
//  MAX_BURST  4  max words accepted per ownership (1..16)
// PORTS
//  clk           in   1                clock; all logic on posedge
//  rst_n         in   1                asynchronous reset, active-low
//  req           in   NUM_REQ          per-requester "has word" level
//  req_data      in   NUM_REQ*DATA_W   packed words, slot i = [i*DATA_W +: DATA_W]
//  gnt           out  NUM_REQ          one-hot; gnt[i]=1 means the word of requester i was taken this cycle
//  fifo_full     in   1                fifo full flag (combinational from fifo)
//  fifo_wr_en    out  1                fifo write enable
//  fifo_data_in  out  DATA_W           fifo write data
//  owner         out  $clog2(NUM_REQ)  current owner index (debug/status)
//  busy          out  1                1 while state==OWN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, owner=NUM_REQ-1 (so req[0] wins first), burst_cnt=0, gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
//  States: IDLE, OWN.
//  - IDLE: if |req, then owner<=rr_pick(req, owner+1), burst_cnt<=0, go to OWN. There is 1 cycle of arbitration latency and no write in IDLE.
//  - OWN:
//    - fifo_wr_en = req[owner] & ~fifo_full (combinational).
//    - gnt = fifo_wr_en << owner.
//    - fifo_data_in = req_data slot owner, driven even when wr_en=0.
//  Release from OWN happens when either condition holds:
//    (a) accepted word with burst_cnt==MAX_BURST-1;
//    (b) req[owner]==0.
//  On release:
//    - Compute nxt=rr_pick(req & ~(1<<owner), owner+1).
//    - If any candidate: owner<=nxt, burst_cnt<=0, stay in OWN (no bubble).
//    - Else, for (a) with req[owner] still 1: keep owner, burst_cnt<=0, stay OWN.
//    - Else go to IDLE with owner unchanged.
//  burst_cnt increments only on an accepted word. fifo_full stalls the owner: no count, no release while req[owner]=1.
//  Round-robin: rr_pick searches from index start upward, modulo NUM_REQ. Owner index wraps NUM_REQ-1 -> 0.
//  At most one gnt bit is set per cycle. gnt is never set when fifo_full=1.
//  Requester contract: hold req and the data stable until gnt. Dropping req without gnt is legal and counts as release (b).
//  A requester that asserts req in the same cycle as a release is eligible in that cycle's pick.
//  Reset asserted mid-burst forces IDLE immediately. A partially sent burst is not resumed.
//  No combinational path from req_data to any control output.
// STRUCTURE
//  Shared package fifo_pkg:
//    - state encoding localparams ST_IDLE=1'b0, ST_OWN=1'b1;
//    - FIFO_DATA_W=8, FIFO_DEPTH=16.
//  Sub-module rr_pick: a pure-combinational rotating priority encoder.
//    - Parameter N.
//    - Inputs req[N-1:0] and start[$clog2(N)-1:0].
//    - Outputs idx and valid.
//    - Used once for the IDLE pick and once for the release pick.
//  Top level holds the state register, owner, burst_cnt and the output muxing.
// TESTING
//  T1 reset: rst_n=0 with req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0, owner=3. Then rst_n=1 -> after 1 cycle owner=0 and gnt=0001.
//  T2 burst/rotate: req=1111 held, fifo_full=0 -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001... with no idle cycles between owners.
//  T3 full stall: owner=1 with 2 words sent, fifo_full=1 for 5 cycles -> gnt=0 and owner stays 1. Then full=0 -> 2 more gnt[1] then rotate.
//  T4 early drop: req=0011, requester 0 drops req after 1 word -> owner moves to 1 next cycle. When req=0 overall -> IDLE, busy=0.
//  T5 lone requester: req=0100 for 10 words -> gnt[2] on 10 consecutive cycles after the first arbitration cycle (burst_cnt wraps, no bubble).
//  T6 integration with fifo: 4 producers each write 8 distinct bytes -> fifo never overflows. Read-back contains all 32 bytes, per-producer order preserved.
//     Also assert rst_n mid-burst -> outputs drop to 0 asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 16x8 fifo and its write-side arbiter.
package fifo_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req searching upward
// from start, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] idx,
  output logic          valid
);

  logic [SW:0] s;

  // Descending scan so the lowest offset from start wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, start} + (SW+1)'(k);
      if (s >= (SW+1)'(N)) s = s - (SW+1)'(N);
      if (req[s[SW-1:0]]) begin
        idx   = s[SW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of the fifo write port
// between NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = FIFO_DATA_W,
  parameter  int MAX_BURST = 4,
  localparam int OW        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [0:0]         state;
  logic [CW-1:0]      burst_cnt;
  logic [OW-1:0]      start;
  logic [NUM_REQ-1:0] others;
  logic [OW-1:0]      idle_idx;
  logic [OW-1:0]      rel_idx;
  logic               idle_vld;
  logic               rel_vld;
  logic               own_req;
  logic               last;
  logic               rel;

  assign start   = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign own_req = req[owner];
  assign others  = req & ~(NUM_REQ'(1) << owner);

  assign busy       = (state == ST_OWN);
  assign fifo_wr_en = busy & own_req & ~fifo_full;
  assign gnt        = fifo_wr_en ? (NUM_REQ'(1) << owner) : '0;
  assign fifo_data_in =
    busy ? req_data[owner*DATA_W +: DATA_W] : '0;

  assign last = fifo_wr_en && (burst_cnt == CW'(MAX_BURST - 1));
  assign rel  = last || !own_req;

  rr_pick #(.N(NUM_REQ)) u_pick_idle (
    .req   (req),
    .start (start),
    .idx   (idle_idx),
    .valid (idle_vld)
  );

  rr_pick #(.N(NUM_REQ)) u_pick_rel (
    .req   (others),
    .start (start),
    .idx   (rel_idx),
    .valid (rel_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (idle_vld) begin
            state     <= ST_OWN;
            owner     <= idle_idx;
            burst_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (rel) begin
            burst_cnt <= '0;
            // A lone owner that just hit the burst limit keeps the port.
            if (rel_vld) owner <= rel_idx;
            else if (!last) state <= ST_IDLE;
          end else if (fifo_wr_en) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter with a
// queue-based fifo model driving fifo_full.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int OW    = 2;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;
  logic [OW-1:0]    owner;
  logic             busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy)
  );

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic          we;
    logic [DW-1:0] data;
    logic [OW-1:0] owner;
    logic          busy;
  } obs_t;

  obs_t          sbq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rb[$];
  logic [DW-1:0] sent[NR][$];

  int n_cmp = 0;
  int n_bad = 0;
  int p_pop = 100;

  bit m_busy;
  int m_own;
  int m_cnt;
  bit pr_req[NR];
  int pr_seq[NR];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has(logic [NR-1:0] r, int i);
    return ((r >> i) & 1) != 0;
  endfunction

  function automatic int rr(logic [NR-1:0] r, int first);
    for (int k = 0; k < NR; k++)
      if (has(r, (first + k) % NR)) return (first + k) % NR;
    return -1;
  endfunction

  // Producer i's current word: id in the top bits, sequence below.
  function automatic logic [DW-1:0] word(int i);
    return DW'((i << 6) | (pr_seq[i] % 64));
  endfunction

  always @(negedge clk) begin
    obs_t e, a;
    if (rst_n) begin
      if (fifo_wr_en) begin
        fq.push_back(fifo_data_in);
        check("overflow", 64'(fq.size() > DEPTH), 64'(0));
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = {gnt, fifo_wr_en, (e.busy ? fifo_data_in : {DW{1'b0}}),
             owner, busy};
        check("cycle", 64'(a), 64'(e));
      end
      if (fq.size() > 0 && $urandom_range(99) < p_pop)
        rb.push_back(fq.pop_front());
    end
  end

  task automatic cycle(logic [NR-1:0] mask, int p_req, int p_drop);
    logic [NR-1:0] r;
    obs_t e;
    bit we, nbusy;
    int nown, ncnt, cand;
    for (int i = 0; i < NR; i++) begin
      if (!mask[i]) pr_req[i] = 0;
      else if (pr_req[i] && $urandom_range(99) < p_drop) pr_req[i] = 0;
      else if (!pr_req[i] && $urandom_range(99) < p_req) pr_req[i] = 1;
      r[i] = pr_req[i];
      req_data[i*DW +: DW] = word(i);
    end
    req = r;
    fifo_full = (fq.size() >= DEPTH);

    we = m_busy && has(r, m_own) && !fifo_full;
    e.gnt   = we ? NR'(1 << m_own) : '0;
    e.we    = we;
    e.data  = m_busy ? word(m_own) : '0;
    e.owner = OW'(m_own);
    e.busy  = m_busy;
    sbq.push_back(e);

    nbusy = m_busy;
    nown  = m_own;
    ncnt  = m_cnt;
    if (!m_busy) begin
      if (r != 0) begin
        nbusy = 1;
        nown  = rr(r, (m_own + 1) % NR);
        ncnt  = 0;
      end
    end else begin
      ncnt = m_cnt + (we ? 1 : 0);
      if ((we && ncnt == MB) || !has(r, m_own)) begin
        cand = rr(r & ~NR'(1 << m_own), (m_own + 1) % NR);
        ncnt = 0;
        if (cand >= 0) nown = cand;
        else if (!has(r, m_own)) nbusy = 0;
      end
    end

    if (we) begin
      sent[m_own].push_back(word(m_own));
      pr_seq[m_own]++;
      pr_req[m_own] = 0;
    end

    @(posedge clk);
    #1;
    m_busy = nbusy;
    m_own  = nown;
    m_cnt  = ncnt;
  endtask

  task automatic run(int n, logic [NR-1:0] mask, int p_req, int p_drop,
                     int pop);
    p_pop = pop;
    repeat (n) cycle(mask, p_req, p_drop);
  endtask

  task automatic rst_check(string tag);
    check({tag, "_gnt"},   64'(gnt),          64'(0));
    check({tag, "_we"},    64'(fifo_wr_en),   64'(0));
    check({tag, "_busy"},  64'(busy),         64'(0));
    check({tag, "_owner"}, 64'(owner),        64'(NR - 1));
    check({tag, "_data"},  64'(fifo_data_in), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int bad;
    for (int i = 0; i < NR; i++) begin
      pr_req[i] = 1;
      pr_seq[i] = 0;
      req_data[i*DW +: DW] = word(i);
    end
    req = '1;
    fifo_full = 1'b0;
    m_busy = 0;
    m_own  = NR - 1;
    m_cnt  = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_check("reset");
    rst_n = 1'b1;

    run(40, 4'b1111, 100, 0, 100);
    run(60, 4'b1111, 100, 0, 20);
    run(60, 4'b0011, 70, 20, 60);
    run(8, 4'b0000, 0, 0, 100);
    run(30, 4'b0100, 100, 0, 100);
    run(6, 4'b1111, 100, 0, 100);

    rst_n = 1'b0;
    #1;
    rst_check("midrst");
    m_busy = 0;
    m_own  = NR - 1;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(200, 4'b1111, 60, 10, 50);
    run(80, 4'b1111, 100, 0, 15);
    run(20, 4'b0000, 0, 0, 100);

    while (fq.size() > 0) rb.push_back(fq.pop_front());
    for (int i = 0; i < NR; i++) begin
      got.delete();
      foreach (rb[j])
        if (rb[j][DW-1 -: 2] == 2'(i)) got.push_back(rb[j]);
      check($sformatf("count%0d", i), 64'(got.size()),
            64'(sent[i].size()));
      bad = 0;
      foreach (got[j])
        if (j < sent[i].size() && got[j] !== sent[i][j]) bad++;
      check($sformatf("order%0d", i), 64'(bad), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
